// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and helpers for the RV32IC fetch/realign front end.
package fetch_pkg;

    localparam logic [1:0] OPC_UNCOMPRESSED = 2'b11;
    localparam int         HW_W             = 16;

    typedef enum logic {
        S_RUN     = 1'b0,
        S_DISCARD = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] swap_bytes(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_realign_queue_hw_queue.sv
// Circular halfword buffer: up to two pushes and two pops per cycle, flush empties it.
module hw_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH_HW = 8,
    localparam int CNT_W    = count_w(DEPTH_HW),
    localparam int PTR_W    = $clog2(DEPTH_HW)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic [1:0]       i_push_n,
    input  logic [HW_W-1:0]  i_push_hw0,
    input  logic [HW_W-1:0]  i_push_hw1,
    input  logic [1:0]       i_pop_n,
    output logic [HW_W-1:0]  o_h0,
    output logic [HW_W-1:0]  o_h1,
    output logic [CNT_W-1:0] o_count
);

    logic [HW_W-1:0]  r_mem [DEPTH_HW];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_rd_ptr1;
    logic [PTR_W-1:0] w_wr_ptr1;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    assign w_rd_ptr1 = r_rd_ptr + PTR_W'(1);
    assign w_wr_ptr1 = r_wr_ptr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(i_push_n);
            r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop_n);
            r_count  <= r_count + CNT_W'(i_push_n) - CNT_W'(i_pop_n);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !i_flush) begin
            if (i_push_n != 2'd0) begin
                r_mem[r_wr_ptr] <= i_push_hw0;
            end
            if (i_push_n == 2'd2) begin
                r_mem[w_wr_ptr1] <= i_push_hw1;
            end
        end
    end

    assign o_h0    = r_mem[r_rd_ptr];
    assign o_h1    = r_mem[w_rd_ptr1];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_realign_queue.sv
// RV32IC fetch front end: sequential word prefetch into a halfword queue, 16/32-bit realignment, redirect.
module fetch_realign_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH_HW   = 8,
    parameter int          SWAP_BYTES = 1,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_compressed,
    output logic        ICACHE_ren,
    output logic        ICACHE_wen,
    output logic [29:0] ICACHE_addr,
    output logic [31:0] ICACHE_wdata,
    input  logic [31:0] ICACHE_rdata,
    input  logic        ICACHE_stall
);

    localparam int               CNT_W     = count_w(DEPTH_HW);
    localparam logic [CNT_W-1:0] ISSUE_MAX = CNT_W'(DEPTH_HW - 2);

    // Cache handshake: a request is live while ICACHE_ren=1 and completes on the
    // first cycle with ICACHE_stall=0; address and ren stay frozen while stalled.
    fetch_state_e r_state;
    fetch_state_e w_state_nxt;

    logic [29:0] r_fetch_addr;
    logic [29:0] r_req_addr;
    logic        r_hold;
    logic        r_drop_lo;
    logic [31:0] r_out_pc;

    logic [HW_W-1:0]  w_h0;
    logic [HW_W-1:0]  w_h1;
    logic [CNT_W-1:0] w_count;
    logic             w_comp;
    logic             w_stalled;
    logic             w_complete;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_push_n;
    logic [1:0]       w_pop_n;
    logic [31:0]      w_word;
    logic [HW_W-1:0]  w_push_hw0;
    logic [HW_W-1:0]  w_push_hw1;

    hw_queue #(
        .DEPTH_HW (DEPTH_HW)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (redirect),
        .i_push_n   (w_push_n),
        .i_push_hw0 (w_push_hw0),
        .i_push_hw1 (w_push_hw1),
        .i_pop_n    (w_pop_n),
        .o_h0       (w_h0),
        .o_h1       (w_h1),
        .o_count    (w_count)
    );

    // Issue on pre-pop occupancy so a full word always fits when it returns.
    assign ICACHE_ren   = rst_n && ((w_count <= ISSUE_MAX) || r_hold || (r_state == S_DISCARD));
    assign ICACHE_addr  = r_hold ? r_req_addr : r_fetch_addr;
    assign ICACHE_wen   = 1'b0;
    assign ICACHE_wdata = 32'h0;

    assign w_stalled  = ICACHE_ren && ICACHE_stall;
    assign w_complete = ICACHE_ren && !ICACHE_stall;
    assign w_push     = w_complete && (r_state == S_RUN) && !redirect;
    assign w_word     = (SWAP_BYTES != 0) ? swap_bytes(ICACHE_rdata) : ICACHE_rdata;

    // A halfword-aligned target skips the low half of its first word.
    assign w_push_n   = !w_push ? 2'd0 : (r_drop_lo ? 2'd1 : 2'd2);
    assign w_push_hw0 = r_drop_lo ? w_word[31:16] : w_word[15:0];
    assign w_push_hw1 = w_word[31:16];

    assign w_comp         = (w_h0[1:0] != OPC_UNCOMPRESSED);
    assign out_valid      = !redirect && (((w_count != '0) && w_comp) || (w_count >= CNT_W'(2)));
    assign out_inst       = w_comp ? {16'h0, w_h0} : {w_h1, w_h0};
    assign out_pc         = r_out_pc;
    assign out_compressed = w_comp;

    assign w_pop   = out_valid && out_ready;
    assign w_pop_n = !w_pop ? 2'd0 : (w_comp ? 2'd1 : 2'd2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The stalled request's data belongs to the old stream, so it is dropped on completion.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (redirect && w_stalled) begin
                    w_state_nxt = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (!ICACHE_stall) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_addr <= RESET_PC[31:2];
            r_req_addr   <= RESET_PC[31:2];
            r_drop_lo    <= RESET_PC[1];
            r_out_pc     <= RESET_PC & 32'hFFFF_FFFE;
            r_hold       <= 1'b0;
        end else begin
            r_hold <= w_stalled;
            if (w_stalled) begin
                r_req_addr <= ICACHE_addr;
            end
            if (redirect) begin
                r_fetch_addr <= redirect_pc[31:2];
                r_drop_lo    <= redirect_pc[1];
                r_out_pc     <= redirect_pc & 32'hFFFF_FFFE;
            end else begin
                if (w_push) begin
                    r_fetch_addr <= r_fetch_addr + 30'd1;
                    r_drop_lo    <= 1'b0;
                end
                if (w_pop) begin
                    r_out_pc <= r_out_pc + (w_comp ? 32'd2 : 32'd4);
                end
            end
        end
    end

endmodule
